// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS core: instruction fields, opcode and
// funct encodings, memory-interface FSM states and default widths.
package mips_pkg;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 16;

  localparam int OP_MSB     = 31;
  localparam int OP_LSB     = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int TARGET_MSB = 25;
  localparam int TARGET_LSB = 0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_SLL = 6'h00;
  localparam logic [5:0] FUNCT_SRL = 6'h02;
  localparam logic [5:0] FUNCT_JR  = 6'h08;
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_XOR = 6'h26;
  localparam logic [5:0] FUNCT_NOR = 6'h27;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_if_state_t;

endpackage

// File: rtl/mips_mem_if_if.sv
// Valid/ready bus between the MIPS memory interface stage (master) and the
// unified instruction/data memory (slave).
interface mips_mem_if_if
  import mips_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              mem_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_valid, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mips_mem_if_watchdog.sv
// Access watchdog: counts ACCESS cycles without mem_ready and flags expiry in the
// cycle that would make the stall TIMEOUT cycles long.
module mem_if_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expired
);
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  assign expired = tick && (count == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick) begin
      count <= count + CNT_W'(1);
    end
  end
endmodule

// File: rtl/mips_mem_if.sv
// Memory interface stage of the multicycle MIPS core: owns IR and MDR and turns the
// control's access request into a valid/ready transaction. Optional watchdog: MEM_IF_WATCHDOG_EN.
module mips_mem_if
  import mips_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              i_or_d,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] instr,
  output logic [5:0]        op,
  output logic [5:0]        funct,
  output logic [DATA_W-1:0] mdr,
  output logic              bus_err,
  mips_mem_if_if.master     mem
);

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("mips_mem_if: TIMEOUT must be at least 1");
  end

  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  mem_if_state_t     state, state_next;
  logic              start;
  logic              capture;
  logic              timeout;
  logic              is_data;
  logic              we_q;
  logic [ADDR_W-1:0] addr_sel;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  assign start    = (state == IDLE) && req;
  assign capture  = (state == ACCESS) && mem.mem_ready;
  assign addr_sel = i_or_d ? alu_out : pc;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: next state gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (req) state_next = ACCESS;
      ACCESS:  if (mem.mem_ready || timeout) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request attributes are frozen at acceptance; the control may wander during ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      is_data <= 1'b0;
    end else if (start) begin
      addr_q  <= addr_sel & WORD_MASK;
      wdata_q <= wdata;
      we_q    <= i_or_d & mem_write;
      is_data <= i_or_d;
    end
  end

  // NOTE: IR and MDR are architectural registers with defined reset values, so
  // they take the async reset like any other flop rather than being left unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr <= '0;
      mdr   <= '0;
    end else if (capture) begin
      if (!is_data)   instr <= mem.mem_rdata;
      else if (!we_q) mdr   <= mem.mem_rdata;
    end
  end

  assign mem.mem_valid = (state == ACCESS);
  assign mem.mem_we    = we_q & mem.mem_valid;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  assign op    = instr[OP_MSB:OP_LSB];
  assign funct = instr[FUNCT_MSB:FUNCT_LSB];

`ifdef MEM_IF_WATCHDOG_EN
  mem_if_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (start),
    .tick    ((state == ACCESS) && !mem.mem_ready),
    .expired (timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          bus_err <= 1'b0;
    else if (timeout) bus_err <= 1'b1;
  end
`else
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif

endmodule
